// File: rtl/lvds_lane_aligner.sv
// Word-aligns every LVDS deserializer lane against an ADC training pattern by
// pulsing the per-lane bitslip, and forwards rx_in downstream one cycle late.
module lvds_lane_aligner #(
  parameter int unsigned  NLANES        = 14,
  parameter int unsigned  J             = 10,
  parameter logic [J-1:0] PATTERN       = 10'h2AA,
  parameter int unsigned  MATCH_COUNT   = 16,
  parameter int unsigned  SETTLE_CYCLES = 8,
  parameter int unsigned  MAX_SLIPS     = 20
) (
  input  logic                clklvds,
  input  logic                rstn,
  input  logic                start,
  input  logic [NLANES*J-1:0] rx_in,
  output logic [NLANES*J-1:0] bits_out,
  output logic [NLANES-1:0]   bitslip,
  output logic [NLANES-1:0]   lane_locked,
  output logic [NLANES-1:0]   lane_failed,
  output logic                busy,
  output logic                align_done,
  output logic                align_fail
);

  localparam int unsigned MW = $clog2(MATCH_COUNT + 1);
  localparam int unsigned SW = $clog2(MAX_SLIPS + 1);
  localparam int unsigned TW = $clog2(SETTLE_CYCLES + 1);

  localparam logic [MW-1:0] MATCH_LAST  = MW'(MATCH_COUNT - 1);
  localparam logic [SW-1:0] SLIP_MAX    = SW'(MAX_SLIPS);
  localparam logic [TW-1:0] SETTLE_LAST = TW'(SETTLE_CYCLES - 1);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_CHECK  = 3'd1,
    S_SLIP   = 3'd2,
    S_SETTLE = 3'd3,
    S_LOCKED = 3'd4,
    S_FAIL   = 3'd5
  } lane_state_e;

  logic                w_start_acc;
  logic [NLANES-1:0]   w_term_next;
  logic [NLANES-1:0]   w_fail_next;
  logic [NLANES*J-1:0] r_bits;
  logic                r_busy;
  logic                r_done;
  logic                r_fail;

  // A start is only honoured when no alignment is in flight.
  assign w_start_acc = start & ~r_busy;

  for (genvar k = 0; k < NLANES; k++) begin : g_lane
    lane_state_e   r_state;
    logic [MW-1:0] r_match_cnt;
    logic [SW-1:0] r_slip_cnt;
    logic [TW-1:0] r_settle_cnt;
    logic          r_bitslip;
    logic          r_locked;
    logic          r_failed;
    logic          w_match;

    assign w_match = (rx_in[J*k +: J] == PATTERN);

    // Lane will sit in LOCKED or FAIL after this edge; lets done rise in the same cycle.
    assign w_term_next[k] = (r_state == S_LOCKED) || (r_state == S_FAIL) ||
                            ((r_state == S_CHECK) &&
                             (w_match ? (r_match_cnt == MATCH_LAST) : (r_slip_cnt == SLIP_MAX)));
    assign w_fail_next[k] = (r_state == S_FAIL) ||
                            ((r_state == S_CHECK) && !w_match && (r_slip_cnt == SLIP_MAX));

    always_ff @(posedge clklvds or negedge rstn) begin
      if (!rstn) begin
        r_state      <= S_IDLE;
        r_match_cnt  <= '0;
        r_slip_cnt   <= '0;
        r_settle_cnt <= '0;
        r_bitslip    <= 1'b0;
        r_locked     <= 1'b0;
        r_failed     <= 1'b0;
      end else begin
        r_bitslip <= 1'b0;
        if (w_start_acc) begin
          r_state      <= S_CHECK;
          r_match_cnt  <= '0;
          r_slip_cnt   <= '0;
          r_settle_cnt <= '0;
          r_locked     <= 1'b0;
          r_failed     <= 1'b0;
        end else begin
          unique case (r_state)
            S_CHECK: begin
              if (w_match) begin
                r_match_cnt <= r_match_cnt + 1'b1;
                if (r_match_cnt == MATCH_LAST) begin
                  r_state  <= S_LOCKED;
                  r_locked <= 1'b1;
                end
              end else begin
                r_match_cnt <= '0;
                if (r_slip_cnt == SLIP_MAX) begin
                  r_state  <= S_FAIL;
                  r_failed <= 1'b1;
                end else begin
                  r_state   <= S_SLIP;
                  r_bitslip <= 1'b1;
                end
              end
            end
            S_SLIP: begin
              r_state      <= S_SETTLE;
              r_settle_cnt <= '0;
              if (r_slip_cnt != SLIP_MAX) r_slip_cnt <= r_slip_cnt + 1'b1;
            end
            // Words arriving while the deserializer settles are ignored.
            S_SETTLE: begin
              r_settle_cnt <= r_settle_cnt + 1'b1;
              if (r_settle_cnt == SETTLE_LAST) r_state <= S_CHECK;
            end
            default: ;
          endcase
        end
      end
    end

    assign bitslip[k]     = r_bitslip;
    assign lane_locked[k] = r_locked;
    assign lane_failed[k] = r_failed;
  end

  // Pass-through register and aggregate status.
  always_ff @(posedge clklvds or negedge rstn) begin
    if (!rstn) begin
      r_bits <= '0;
      r_busy <= 1'b0;
      r_done <= 1'b0;
      r_fail <= 1'b0;
    end else begin
      r_bits <= rx_in;
      if (w_start_acc) begin
        r_busy <= 1'b1;
        r_done <= 1'b0;
        r_fail <= 1'b0;
      end else if (r_busy && (&w_term_next)) begin
        r_busy <= 1'b0;
        r_done <= 1'b1;
        r_fail <= |w_fail_next;
      end
    end
  end

  assign bits_out   = r_bits;
  assign busy       = r_busy;
  assign align_done = r_done;
  assign align_fail = r_fail;

endmodule
